// File: rtl/multicycle_control.sv
// Multi-cycle control unit for the RV64 core.
// It accepts one instruction at a time over a valid/ready handshake, decodes it
// in a single DECODE cycle, then runs EXEC or MEM (with a bounded req/ack wait)
// and WB for loads. Illegal encodings are flagged in DECODE and dropped.
module multicycle_control #(
  parameter int XLEN        = 64,
  parameter int MEM_TIMEOUT = 16,
  parameter bit SUPPORT_W   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  rw_type,
  output logic [1:0]  alu_op,
  output logic        alu_src,
  output logic        word_op,
  output logic        mem_to_reg,
  output logic        lui,
  output logic        auipc,
  output logic        jal,
  output logic        jalr,
  output logic [5:0]  br_type,
  output logic        reg_write,
  output logic        done,
  output logic        illegal,
  output logic        timeout_err,
  output logic        busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_IMM32  = 7'b0011011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;

  // Last counter value of the MEM wait; reaching it without ack ends the access.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]  state_reg, state_next;
  logic [31:0] instr_reg;
  logic [7:0]  cnt_reg, cnt_next;

  // Registered decode results, presented from the first EXEC/MEM cycle.
  logic [1:0]  alu_op_reg;
  logic        alu_src_reg, word_op_reg, mem_to_reg_reg, mem_we_reg;
  logic [2:0]  rw_type_reg;
  logic        lui_reg, auipc_reg, jal_reg, jalr_reg;
  logic [5:0]  br_type_reg;
  logic        wb_en_reg;

  // Combinational decode of the latched instruction.
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr;
  logic        is_lui, is_auipc, is_w_imm, is_w_reg, known;
  logic        dec_illegal, dec_wb_en;
  logic [1:0]  dec_alu_op;
  logic [5:0]  dec_br_type;
  logic        unused_instr_bits;

  assign opcode = instr_reg[6:0];
  assign f3     = instr_reg[14:12];
  assign unused_instr_bits = ^{instr_reg[31:15], instr_reg[11:7]};

  assign is_r      = (opcode == OPC_R);
  assign is_i      = (opcode == OPC_I);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_w_imm  = (SUPPORT_W != 1'b0) && (opcode == OPC_IMM32);
  assign is_w_reg  = (SUPPORT_W != 1'b0) && (opcode == OPC_OP32);

  assign known = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr |
                 is_lui | is_auipc | is_w_imm | is_w_reg;

  // Branch func3 010/011 are reserved, load 111 has no width, stores stop at 011.
  assign dec_illegal = (instr_reg[1:0] != 2'b11) | ~known |
                       (is_branch & (f3[2:1] == 2'b01)) |
                       (is_load & (f3 == 3'b111)) |
                       (is_store & f3[2]);

  assign dec_wb_en = is_r | is_i | is_w_imm | is_w_reg | is_jal | is_jalr | is_lui | is_auipc;

  // One-hot branch type: bits 0..1 map to func3 000/001, bits 2..5 to func3 100..111.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_br_type
      localparam logic [2:0] BR_F3 = (gi < 2) ? 3'(gi) : 3'(gi + 2);
      assign dec_br_type[gi] = is_branch & (f3 == BR_F3);
    end
  endgenerate

  // ALU operation class selected from the opcode group.
  always_comb begin
    dec_alu_op = 2'b00;
    if (is_r | is_w_reg)
      dec_alu_op = 2'b10;
    else if (is_i | is_w_imm)
      dec_alu_op = 2'b01;
    else if (is_branch)
      dec_alu_op = 2'b11;
  end

  // Next-state logic plus the single-cycle pulses tied to the current state.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    done        = 1'b0;
    illegal     = 1'b0;
    timeout_err = 1'b0;
    reg_write   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (instr_valid)
          state_next = S_DECODE;
      end
      S_DECODE: begin
        cnt_next = 8'd0;
        if (dec_illegal) begin
          illegal    = 1'b1;
          state_next = S_IDLE;
        end else if (is_load | is_store) begin
          state_next = S_MEM;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        done       = 1'b1;
        reg_write  = wb_en_reg;
        state_next = S_IDLE;
      end
      S_MEM: begin
        // An ack arriving in the last allowed cycle still completes the access.
        if (mem_ack) begin
          if (mem_we_reg) begin
            done       = 1'b1;
            state_next = S_IDLE;
          end else begin
            state_next = S_WB;
          end
        end else if (cnt_reg == TIMEOUT_LAST) begin
          timeout_err = 1'b1;
          state_next  = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      S_WB: begin
        done       = 1'b1;
        reg_write  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, instruction latch and MEM wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      instr_reg <= 32'd0;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == S_IDLE && instr_valid)
        instr_reg <= instr;
    end
  end

  // Decode outputs load at the end of a legal DECODE and clear on return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_reg     <= 2'b00;
      alu_src_reg    <= 1'b0;
      word_op_reg    <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      mem_we_reg     <= 1'b0;
      rw_type_reg    <= 3'b000;
      lui_reg        <= 1'b0;
      auipc_reg      <= 1'b0;
      jal_reg        <= 1'b0;
      jalr_reg       <= 1'b0;
      br_type_reg    <= 6'b0;
      wb_en_reg      <= 1'b0;
    end else if (state_reg == S_DECODE && !dec_illegal) begin
      alu_op_reg     <= dec_alu_op;
      alu_src_reg    <= is_load | is_store | is_i | is_jalr | is_w_imm;
      word_op_reg    <= is_w_imm | is_w_reg;
      mem_to_reg_reg <= is_load;
      mem_we_reg     <= is_store;
      rw_type_reg    <= (is_load | is_store) ? f3 : 3'b000;
      lui_reg        <= is_lui;
      auipc_reg      <= is_auipc;
      jal_reg        <= is_jal;
      jalr_reg       <= is_jalr;
      br_type_reg    <= dec_br_type;
      wb_en_reg      <= dec_wb_en;
    end else if (state_next == S_IDLE) begin
      alu_op_reg     <= 2'b00;
      alu_src_reg    <= 1'b0;
      word_op_reg    <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      mem_we_reg     <= 1'b0;
      rw_type_reg    <= 3'b000;
      lui_reg        <= 1'b0;
      auipc_reg      <= 1'b0;
      jal_reg        <= 1'b0;
      jalr_reg       <= 1'b0;
      br_type_reg    <= 6'b0;
      wb_en_reg      <= 1'b0;
    end
  end

  // Only the RV64 datapath width and an 8-bit timeout counter are supported.
  assert property (@(posedge clk) (XLEN == 64) && (MEM_TIMEOUT >= 1) && (MEM_TIMEOUT <= 255));

  assign instr_ready = (state_reg == S_IDLE);
  assign busy        = (state_reg != S_IDLE);
  assign mem_req     = (state_reg == S_MEM);
  assign mem_we      = mem_we_reg;
  assign rw_type     = rw_type_reg;
  assign alu_op      = alu_op_reg;
  assign alu_src     = alu_src_reg;
  assign word_op     = word_op_reg;
  assign mem_to_reg  = mem_to_reg_reg;
  assign lui         = lui_reg;
  assign auipc       = auipc_reg;
  assign jal         = jal_reg;
  assign jalr        = jalr_reg;
  assign br_type     = br_type_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected retire events are queued as
// each instruction is issued and compared when the controller finishes it.
module tb_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic        instr_valid, valid_nw;
  logic [31:0] instr;
  logic        mem_ack;

  // Main instance (W-ops supported)
  logic        instr_ready, mem_req, mem_we, alu_src, word_op, mem_to_reg;
  logic        lui, auipc, jal, jalr, reg_write, done, illegal, timeout_err, busy;
  logic [2:0]  rw_type;
  logic [1:0]  alu_op;
  logic [5:0]  br_type;

  // Instance without W-op support
  logic        n_instr_ready, n_mem_req, n_mem_we, n_alu_src, n_word_op, n_mem_to_reg;
  logic        n_lui, n_auipc, n_jal, n_jalr, n_reg_write, n_done, n_illegal, n_timeout_err, n_busy;
  logic [2:0]  n_rw_type;
  logic [1:0]  n_alu_op;
  logic [5:0]  n_br_type;

  multicycle_control #(.XLEN(64), .MEM_TIMEOUT(16), .SUPPORT_W(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .rw_type(rw_type), .alu_op(alu_op), .alu_src(alu_src), .word_op(word_op),
    .mem_to_reg(mem_to_reg), .lui(lui), .auipc(auipc), .jal(jal), .jalr(jalr),
    .br_type(br_type), .reg_write(reg_write), .done(done), .illegal(illegal),
    .timeout_err(timeout_err), .busy(busy)
  );

  multicycle_control #(.XLEN(64), .MEM_TIMEOUT(16), .SUPPORT_W(1'b0)) u_dut_nw (
    .clk(clk), .rst_n(rst_n), .instr_valid(valid_nw), .instr(instr),
    .instr_ready(n_instr_ready), .mem_ack(mem_ack), .mem_req(n_mem_req), .mem_we(n_mem_we),
    .rw_type(n_rw_type), .alu_op(n_alu_op), .alu_src(n_alu_src), .word_op(n_word_op),
    .mem_to_reg(n_mem_to_reg), .lui(n_lui), .auipc(n_auipc), .jal(n_jal), .jalr(n_jalr),
    .br_type(n_br_type), .reg_write(n_reg_write), .done(n_done), .illegal(n_illegal),
    .timeout_err(n_timeout_err), .busy(n_busy)
  );

  // Output bundle: [25] ready [24] busy [23] done [22] illegal [21] timeout_err
  // [20] reg_write [19] mem_req, [18:0] decode fields.
  logic [25:0] obs_w, obs_n;
  assign obs_w = {instr_ready, busy, done, illegal, timeout_err, reg_write, mem_req,
                  mem_we, mem_to_reg, word_op, alu_src, lui, auipc, jal, jalr,
                  alu_op, rw_type, br_type};
  assign obs_n = {n_instr_ready, n_busy, n_done, n_illegal, n_timeout_err, n_reg_write, n_mem_req,
                  n_mem_we, n_mem_to_reg, n_word_op, n_alu_src, n_lui, n_auipc, n_jal, n_jalr,
                  n_alu_op, n_rw_type, n_br_type};

  localparam logic [25:0] IDLE_OBS = 26'h200_0000;

  typedef struct packed {
    logic [7:0]  lat;
    logic        dn;
    logic        ill;
    logic        tmo;
    logic [1:0]  rwc;
    logic [7:0]  memc;
    logic [18:0] dec;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [18:0] dec(input logic we, input logic m2r, input logic wop,
                                      input logic asrc, input logic [3:0] cls,
                                      input logic [1:0] aop, input logic [2:0] rwt,
                                      input logic [5:0] br);
    return {we, m2r, wop, asrc, cls, aop, rwt, br};
  endfunction

  task automatic push_exp(input int lat, input logic dn, input logic ill, input logic tmo,
                          input int rwc, input int memc, input logic [18:0] d);
    exp_t e;
    e.lat  = 8'(lat);
    e.dn   = dn;
    e.ill  = ill;
    e.tmo  = tmo;
    e.rwc  = 2'(rwc);
    e.memc = 8'(memc);
    e.dec  = d;
    sb.push_back(e);
  endtask

  // Issue one instruction, follow it to completion and compare with the queued expectation.
  // ack_at: MEM cycle index (0-based) in which mem_ack is pulsed, -1 for never.
  task automatic run(input string tag, input logic [31:0] iw, input bit use_nw, input int ack_at);
    int cyc, memc, rwc;
    bit fin, leak;
    logic [25:0] o, o_fin;
    exp_t e;
    @(negedge clk);
    instr = iw;
    if (use_nw) valid_nw = 1'b1; else instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    valid_nw    = 1'b0;
    instr       = 32'hFFFF_FFFF;
    cyc = 1; memc = 0; rwc = 0; fin = 1'b0; leak = 1'b0; o_fin = '0;
    while (!fin && cyc < 64) begin
      o = use_nw ? obs_n : obs_w;
      mem_ack = (!use_nw && o[19] && memc == ack_at);
      #1;
      o = use_nw ? obs_n : obs_w;
      if (o[19]) memc++;
      if (o[20]) rwc++;
      if (o[25] || !o[24]) leak = 1'b1;
      if (cyc == 1 && o[18:0] != 19'd0) leak = 1'b1;
      if (o[23] || o[22] || o[21]) begin
        fin   = 1'b1;
        o_fin = o;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "/finished"}, 32'(fin), 32'd1);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check({tag, "/idle_after"}, 32'(use_nw ? obs_n : obs_w), 32'(IDLE_OBS));
    if (sb.size() == 0) begin
      check({tag, "/scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "/latency"},     32'(cyc),       32'(e.lat));
      check({tag, "/done"},        32'(o_fin[23]), 32'(e.dn));
      check({tag, "/illegal"},     32'(o_fin[22]), 32'(e.ill));
      check({tag, "/timeout_err"}, 32'(o_fin[21]), 32'(e.tmo));
      check({tag, "/reg_writes"},  32'(rwc),       32'(e.rwc));
      check({tag, "/mem_req_cyc"}, 32'(memc),      32'(e.memc));
      check({tag, "/decode"},      32'(o_fin[18:0]), 32'(e.dec));
      check({tag, "/busy_ready"},  32'(leak),      32'd0);
      $display("txn %s instr=%08h lat=%0d memc=%0d obs=%07h", tag, iw, cyc, memc, o_fin);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    valid_nw    = 1'b0;
    instr       = 32'd0;
    mem_ack     = 1'b0;
    #1;
    check("reset/main", 32'(obs_w), 32'(IDLE_OBS));
    check("reset/nw",   32'(obs_n), 32'(IDLE_OBS));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // add x1,x2,x3
    push_exp(2, 1, 0, 0, 1, 0, dec(0, 0, 0, 0, 4'b0000, 2'b10, 3'b000, 6'b0));
    run("add", 32'h003100B3, 1'b0, -1);
    // addi
    push_exp(2, 1, 0, 0, 1, 0, dec(0, 0, 0, 1, 4'b0000, 2'b01, 3'b000, 6'b0));
    run("addi", 32'h00108093, 1'b0, -1);
    // ld x5,8(x2), ack in third MEM cycle
    push_exp(5, 1, 0, 0, 1, 3, dec(0, 1, 0, 1, 4'b0000, 2'b00, 3'b011, 6'b0));
    run("ld_ack2", 32'h00813283, 1'b0, 2);
    // sd with no ack: 16 MEM cycles then timeout
    push_exp(17, 0, 0, 1, 0, 16, dec(1, 0, 0, 1, 4'b0000, 2'b00, 3'b011, 6'b0));
    run("sd_timeout", 32'h00513423, 1'b0, -1);
    // sd with ack in the timeout cycle: ack wins
    push_exp(17, 1, 0, 0, 0, 16, dec(1, 0, 0, 1, 4'b0000, 2'b00, 3'b011, 6'b0));
    run("sd_ack15", 32'h00513423, 1'b0, 15);
    // sw with immediate ack
    push_exp(2, 1, 0, 0, 0, 1, dec(1, 0, 0, 1, 4'b0000, 2'b00, 3'b010, 6'b0));
    run("sw_ack0", 32'h00512023, 1'b0, 0);
    // Illegal encodings
    push_exp(1, 0, 1, 0, 0, 0, 19'd0);
    run("ill_opc7f", 32'h0000007F, 1'b0, -1);
    push_exp(1, 0, 1, 0, 0, 0, 19'd0);
    run("ill_br010", 32'h00002063, 1'b0, -1);
    push_exp(1, 0, 1, 0, 0, 0, 19'd0);
    run("ill_ld111", 32'h00007003, 1'b0, -1);
    push_exp(1, 0, 1, 0, 0, 0, 19'd0);
    run("ill_st100", 32'h00004023, 1'b0, -1);
    push_exp(1, 0, 1, 0, 0, 0, 19'd0);
    run("ill_low10", 32'h003100B2, 1'b0, -1);
    push_exp(1, 0, 1, 0, 0, 0, 19'd0);
    run("addw_nw", 32'h003100BB, 1'b1, -1);
    // W-ops with support
    push_exp(2, 1, 0, 0, 1, 0, dec(0, 0, 1, 0, 4'b0000, 2'b10, 3'b000, 6'b0));
    run("addw", 32'h003100BB, 1'b0, -1);
    push_exp(2, 1, 0, 0, 1, 0, dec(0, 0, 1, 1, 4'b0000, 2'b01, 3'b000, 6'b0));
    run("addiw", 32'h0010809B, 1'b0, -1);
    // Branch and class flags
    push_exp(2, 1, 0, 0, 0, 0, dec(0, 0, 0, 0, 4'b0000, 2'b11, 3'b000, 6'b001000));
    run("bge", 32'h00005063, 1'b0, -1);
    push_exp(2, 1, 0, 0, 1, 0, dec(0, 0, 0, 0, 4'b1000, 2'b00, 3'b000, 6'b0));
    run("lui", 32'h000012B7, 1'b0, -1);
    push_exp(2, 1, 0, 0, 1, 0, dec(0, 0, 0, 0, 4'b0100, 2'b00, 3'b000, 6'b0));
    run("auipc", 32'h00000297, 1'b0, -1);
    push_exp(2, 1, 0, 0, 1, 0, dec(0, 0, 0, 0, 4'b0010, 2'b00, 3'b000, 6'b0));
    run("jal", 32'h0000006F, 1'b0, -1);
    push_exp(2, 1, 0, 0, 1, 0, dec(0, 0, 0, 1, 4'b0001, 2'b00, 3'b000, 6'b0));
    run("jalr", 32'h000080E7, 1'b0, -1);

    // Reset asserted in the middle of a MEM wait
    @(negedge clk);
    instr = 32'h00813283;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid/mem_req_before", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid/outputs", 32'(obs_w), 32'(IDLE_OBS));
    $display("txn rst_mid obs=%07h", obs_w);
    @(negedge clk);
    rst_n = 1'b1;

    // Controller still works after the mid-operation reset
    push_exp(2, 1, 0, 0, 1, 0, dec(0, 0, 0, 0, 4'b0000, 2'b10, 3'b000, 6'b0));
    run("add_post_rst", 32'h003100B3, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
FSM-based multi-cycle control unit for the RV64 core. It is the sequential successor of the combinational main decoder.
- Accepts one instruction at a time over a valid/ready handshake and decodes the RV64I opcode set, optionally including the W-ops.
- Sequences EXEC or MEM phases, drives a req/ack data-memory handshake with a timeout, and flags illegal encodings.
- Sits between the fetch buffer and the datapath/LSU.

Parameters:
- XLEN, 64, datapath width; only 64 is legal (RV64). Reserved for assertions.
- MEM_TIMEOUT, 16, max cycles mem_req may stay high without mem_ack (range 1..255).
- SUPPORT_W, 1, 1 = opcodes 0011011 (OP-IMM-32) and 0111011 (OP-32) are legal; 0 = these opcodes are illegal.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  fetch presents instr
- instr  in  32  instruction word
- instr_ready  out  1  controller can accept
- mem_ack  in  1  LSU completion (one-cycle pulse)
- mem_req  out  1  memory request, level
- mem_we  out  1  1 = store
- rw_type  out  3  func3 of the load/store
- alu_op  out  2  R = 10, I/W-imm = 01, B = 11, ld/st/other = 00
- alu_src  out  1  select immediate
- word_op  out  1  W-op (32-bit result, sign-extended)
- mem_to_reg  out  1  writeback from memory
- lui, auipc, jal, jalr  out  1 each  class flags
- br_type  out  6  one-hot {bgeu, bltu, bge, blt, bne, beq}
- reg_write  out  1  writeback strobe (one cycle)
- done  out  1  instruction retired (one cycle)
- illegal  out  1  illegal instruction (one cycle)
- timeout_err  out  1  memory timeout (one cycle)
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n = 0): state = IDLE, instruction register = 0, timeout counter = 0, all outputs 0 except instr_ready = 1.
- States: IDLE, DECODE, EXEC, MEM, WB.
- Handshake: instr_ready = 1 only in IDLE. A transfer is instr_valid & instr_ready; it latches instr and moves to DECODE. instr is ignored in all other states.
- DECODE (1 cycle):
  - Registers all decode outputs.
  - If illegal: pulse illegal, go to IDLE, all decode outputs cleared.
  - Else if load/store: go to MEM. Else: go to EXEC.
- Decode outputs (alu_op, alu_src, word_op, mem_to_reg, mem_we, rw_type, class flags, br_type) are valid and stable from the first EXEC/MEM cycle until the return to IDLE. They are 0 in IDLE and DECODE.
- Opcode map:
  - R 0110011, I 0010011, load 0000011, store 0100011, B 1100011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111, plus W opcodes per SUPPORT_W.
- Decode rules:
  - alu_src = load | store | I | jalr | OP-IMM-32.
  - alu_op: OP-32 = 10, OP-IMM-32 = 01.
  - word_op = either W opcode.
- Illegal conditions:
  - any unlisted opcode
  - instr[1:0] != 2'b11
  - branch func3 010 or 011
  - load func3 111
  - store func3 > 011
  - W opcode when SUPPORT_W = 0
- EXEC (1 cycle): pulse done. Pulse reg_write for R, I, W-ops, jal, jalr, lui, auipc (not B). Next state IDLE.
- MEM:
  - mem_req = 1 each cycle in MEM.
  - Counter starts at 0 on entry and increments each MEM cycle without ack.
  - mem_ack: load -> WB; store -> pulse done, go to IDLE. mem_req drops the cycle after ack.
  - Timeout: if the counter reaches MEM_TIMEOUT - 1 with no ack, pulse timeout_err, drop mem_req, go to IDLE. No done, no reg_write.
  - mem_ack in the same cycle the timeout fires: ack wins, no timeout_err.
- WB (1 cycle): pulse reg_write with mem_to_reg = 1, pulse done, go to IDLE.
- mem_ack outside MEM is ignored.
- Latency:
  - ALU/branch/jump: accept -> done = 2 cycles.
  - Load: 3 + N cycles, where N = ack delay in MEM cycles (0 = ack in first MEM cycle).
  - Store: 2 + N cycles.
- Back-to-back: the earliest next accept is the cycle after done/illegal/timeout (IDLE reached).
- Reset mid-operation: immediate return to IDLE and all outputs cleared. A pending mem_req drops asynchronously.

Test Plan:
- add x1,x2,x3 (0x003100B3) valid in IDLE -> DECODE, then EXEC with alu_op = 10, alu_src = 0, reg_write = 1, done = 1 at cycle 2. instr_ready = 0 during cycles 1–2.
- ld x5,8(x2) (0x00813283), ack after 3 MEM cycles -> mem_req high 3 cycles, mem_we = 0, rw_type = 011. WB cycle has reg_write = 1 and mem_to_reg = 1. done at cycle 5.
- sd (0x00513423), no ack, MEM_TIMEOUT = 16 -> mem_req high exactly 16 cycles, then timeout_err pulse. No done, no reg_write. Next cycle instr_ready = 1.
- Boundary: ack in the 16th MEM cycle (timeout cycle) -> done = 1, timeout_err = 0.
- Illegal: opcode 0x7F, branch func3 010, and addw (0x003100BB) with SUPPORT_W = 0 -> illegal pulse in DECODE, no done, back to IDLE. addw with SUPPORT_W = 1 -> word_op = 1, alu_op = 10, reg_write.
- bge (func3 101) -> br_type = 6'b001000, alu_op = 11, reg_write = 0, done = 1. Assert rst_n low during MEM -> mem_req = 0 immediately, busy = 0, instr_ready = 1.
